stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_pkg.sv | 13 +
 rtl/stack_ptr.sv | 35 +++
 rtl/stack_ctrl.sv | 117 +++++++++++
 tb/tb_stack_ctrl.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/stack_pkg.sv
// Shared types and default sizing for the stack controller.
// The optional high-water mark is enabled with STACK_WATERMARK_EN.
package stack_pkg;

    typedef enum logic {
        RUN   = 1'b0,
        FAULT = 1'b1
    } state_t;

    localparam int DEF_WIDTH  = 16;
    localparam int DEF_NWORDS = 1024;

endpackage

// File: rtl/stack_ptr.sv
// Stack pointer (next free slot) with full/empty decode.
// The pointer saturates at both ends so it can never wrap.
module stack_ptr #(
    parameter  int NWORDS = 1024,
    localparam int AW     = $clog2(NWORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inc,
    input  logic        dec,
    output logic [AW:0] sp,
    output logic        full,
    output logic        empty
);

    localparam logic [AW:0] FULL_SP = (AW+1)'(NWORDS);
    localparam logic [AW:0] ONE     = (AW+1)'(1);

    logic [AW:0] r_sp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sp <= '0;
        end else if (inc && !dec && r_sp != FULL_SP) begin
            r_sp <= r_sp + ONE;
        end else if (dec && !inc && r_sp != '0) begin
            r_sp <= r_sp - ONE;
        end
    end

    assign sp    = r_sp;
    assign full  = (r_sp == FULL_SP);
    assign empty = (r_sp == '0);

endmodule

// File: rtl/stack_ctrl.sv
// LIFO controller driving an external asynchronous-read stack RAM.
// Define STACK_WATERMARK_EN to add the max_depth high-water mark output.
//
//   state | meaning
//   RUN   | push/pop requests are serviced
//   FAULT | overflow/underflow seen; requests ignored until clear_err
module stack_ctrl
    import stack_pkg::*;
#(
    parameter  int WIDTH  = DEF_WIDTH,
    parameter  int NWORDS = DEF_NWORDS,
    localparam int AW     = $clog2(NWORDS)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] push_data,
    input  logic             clear_err,
    output logic [WIDTH-1:0] pop_data,
    output logic             pop_valid,
    output logic             full,
    output logic             empty,
    output logic [AW:0]      depth,
    output logic             fault,
`ifdef STACK_WATERMARK_EN
    output logic [AW:0]      max_depth,
`endif
    output logic             mem_we,
    output logic [AW-1:0]    mem_a,
    output logic [WIDTH-1:0] mem_din,
    input  logic [WIDTH-1:0] mem_dout
);

    state_t           r_state;
    logic [WIDTH-1:0] r_pop_data;
    logic             r_pop_valid;

    logic [AW:0]      w_sp;
    logic             w_full;
    logic             w_empty;
    logic             w_run;
    logic             w_do_push;
    logic             w_do_pop;
    logic             w_swap;
    logic             w_bypass;
    logic             w_overflow;
    logic             w_underflow;
    logic [AW-1:0]    w_top;

    // Reset gates every operation so no RAM write escapes during reset.
    assign w_run       = (r_state == RUN) && !reset;
    assign w_do_push   = w_run &&  push && !pop && !w_full;
    assign w_do_pop    = w_run && !push &&  pop && !w_empty;
    assign w_swap      = w_run &&  push &&  pop && !w_empty;
    assign w_bypass    = w_run &&  push &&  pop &&  w_empty;
    assign w_overflow  = w_run &&  push && !pop &&  w_full;
    assign w_underflow = w_run && !push &&  pop &&  w_empty;

    stack_ptr #(.NWORDS(NWORDS)) u_ptr (
        .clk   (clk),
        .reset (reset),
        .inc   (w_do_push),
        .dec   (w_do_pop),
        .sp    (w_sp),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_top   = w_sp[AW-1:0] - AW'(1);
    assign mem_we  = w_do_push || w_swap;
    assign mem_a   = w_do_push ? w_sp[AW-1:0] : w_top;
    assign mem_din = push_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= RUN;
            r_pop_data  <= '0;
            r_pop_valid <= 1'b0;
        end else begin
            r_pop_valid <= w_do_pop || w_swap || w_bypass;
            if (w_bypass) begin
                r_pop_data <= push_data;
            end else if (w_do_pop || w_swap) begin
                r_pop_data <= mem_dout;
            end
            case (r_state)
                RUN:     if (w_overflow || w_underflow) r_state <= FAULT;
                FAULT:   if (clear_err) r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

`ifdef STACK_WATERMARK_EN
    localparam logic [AW:0] ONE = (AW+1)'(1);
    logic [AW:0] r_max_depth;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_max_depth <= '0;
        end else if (w_do_push && w_sp >= r_max_depth) begin
            r_max_depth <= w_sp + ONE;
        end
    end

    assign max_depth = r_max_depth;
`endif

    assign pop_data  = r_pop_data;
    assign pop_valid = r_pop_valid;
    assign full      = w_full;
    assign empty     = w_empty;
    assign depth     = w_sp;
    assign fault     = (r_state == FAULT);

endmodule

// File: tb/tb_stack_ctrl.sv
// Bench for stack_ctrl (NWORDS=4) with a RAM model and a queue-based LIFO model.
// Build with STACK_WATERMARK_EN defined to also cover max_depth.
module tb_stack_ctrl;

    localparam int W = 16;
    localparam int N = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          push = 1'b0;
    logic          pop = 1'b0;
    logic          clear_err = 1'b0;
    logic [W-1:0]  push_data = '0;
    logic [W-1:0]  pop_data;
    logic          pop_valid;
    logic          full;
    logic          empty;
    logic [2:0]    depth;
    logic          fault;
    logic          mem_we;
    logic [1:0]    mem_a;
    logic [W-1:0]  mem_din;
    logic [W-1:0]  mem_dout;
`ifdef STACK_WATERMARK_EN
    logic [2:0]    max_depth;
`endif

    stack_ctrl #(.WIDTH(W), .NWORDS(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .pop       (pop),
        .push_data (push_data),
        .clear_err (clear_err),
        .pop_data  (pop_data),
        .pop_valid (pop_valid),
        .full      (full),
        .empty     (empty),
        .depth     (depth),
        .fault     (fault),
`ifdef STACK_WATERMARK_EN
        .max_depth (max_depth),
`endif
        .mem_we    (mem_we),
        .mem_a     (mem_a),
        .mem_din   (mem_din),
        .mem_dout  (mem_dout)
    );

    always #5 clk = ~clk;

    logic [W-1:0] ram [0:N-1];
    always @(posedge clk) if (mem_we) ram[mem_a] <= mem_din;
    assign mem_dout = ram[mem_a];

    // Reference model: a LIFO queue plus a fault flag.
    logic [W-1:0] q[$];
    bit           m_fault;
    bit           m_pv;
    logic [W-1:0] m_pd;
    int           m_max;
    bit           exp_we;
    logic [1:0]   exp_a;
    logic         obs_we;
    logic [1:0]   obs_a;
    logic [W-1:0] obs_din;

    int n_checks = 0;
    int n_errors = 0;

    task automatic step(input bit p, input bit o, input logic [W-1:0] d,
                        input bit c, input bit r);
        @(negedge clk);
        push = p; pop = o; push_data = d; clear_err = c; reset = r;
        #1;
        obs_we = mem_we; obs_a = mem_a; obs_din = mem_din;
        exp_we = !r && !m_fault && p && (o ? (q.size() > 0) : (q.size() < N));
        exp_a  = (exp_we && !o) ? 2'(q.size()) : 2'(q.size() - 1);
        m_pv = 1'b0;
        if (r) begin
            q.delete(); m_fault = 1'b0; m_pd = '0; m_max = 0;
        end else if (m_fault) begin
            if (c) m_fault = 1'b0;
        end else if (p && o) begin
            m_pv = 1'b1;
            if (q.size() == 0) m_pd = d;
            else begin m_pd = q[q.size()-1]; q[q.size()-1] = d; end
        end else if (p) begin
            if (q.size() == N) m_fault = 1'b1;
            else q.push_back(d);
        end else if (o) begin
            if (q.size() == 0) m_fault = 1'b1;
            else begin m_pd = q.pop_back(); m_pv = 1'b1; end
        end
        if (q.size() > m_max) m_max = q.size();
        @(posedge clk); #1;
        push = 1'b0; pop = 1'b0; clear_err = 1'b0; reset = 1'b0;
    endtask

    task automatic test_reset();
        step(0, 1, 16'h0, 0, 1);
        n_checks++; if (pop_valid !== 1'b0) begin n_errors++; $display("FAIL reset_pv got %b exp 0", pop_valid); end
        n_checks++; if (pop_data !== 16'h0) begin n_errors++; $display("FAIL reset_pd got %h exp 0000", pop_data); end
        n_checks++; if (depth !== 3'd0 || empty !== 1'b1 || full !== 1'b0) begin n_errors++; $display("FAIL reset_depth got d=%0d e=%b f=%b exp 0/1/0", depth, empty, full); end
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL reset_fault got %b exp 0", fault); end
        n_checks++; if (mem_we !== 1'b0 || mem_a !== 2'd3) begin n_errors++; $display("FAIL reset_idle got we=%b a=%0d exp 0/3", mem_we, mem_a); end
    endtask

    task automatic test_lifo();
        logic [W-1:0] vals [3];
        vals = '{16'h1111, 16'h2222, 16'h3333};
        step(0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, 0, vals[i], 0, 0);
            n_checks++; if (obs_we !== 1'b1 || obs_a !== 2'(i) || obs_din !== vals[i]) begin n_errors++; $display("FAIL lifo_push%0d got we=%b a=%0d din=%h exp 1/%0d/%h", i, obs_we, obs_a, obs_din, i, vals[i]); end
        end
        n_checks++; if (depth !== 3'd3) begin n_errors++; $display("FAIL lifo_depth got %0d exp 3", depth); end
        for (int i = 2; i >= 0; i--) begin
            step(0, 1, 16'h0, 0, 0);
            n_checks++; if (pop_valid !== 1'b1 || pop_data !== vals[i]) begin n_errors++; $display("FAIL lifo_pop%0d got v=%b d=%h exp 1/%h", i, pop_valid, pop_data, vals[i]); end
        end
        step(0, 0, 16'h0, 0, 0);
        n_checks++; if (pop_valid !== 1'b0) begin n_errors++; $display("FAIL lifo_pulse got %b exp 0", pop_valid); end
        n_checks++; if (empty !== 1'b1 || depth !== 3'd0) begin n_errors++; $display("FAIL lifo_empty got e=%b d=%0d exp 1/0", empty, depth); end
    endtask

    task automatic test_overflow();
        step(0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 4; i++) step(1, 0, W'($urandom), 0, 0);
        n_checks++; if (full !== 1'b1 || depth !== 3'd4) begin n_errors++; $display("FAIL ovf_full got f=%b d=%0d exp 1/4", full, depth); end
        step(1, 0, 16'h5555, 0, 0);
        n_checks++; if (obs_we !== 1'b0) begin n_errors++; $display("FAIL ovf_we got %b exp 0", obs_we); end
        n_checks++; if (fault !== 1'b1 || depth !== 3'd4) begin n_errors++; $display("FAIL ovf_fault got f=%b d=%0d exp 1/4", fault, depth); end
        n_checks++; if (ram[0] !== q[0]) begin n_errors++; $display("FAIL ovf_ram0 got %h exp %h", ram[0], q[0]); end
        step(0, 0, 16'h0, 1, 0);
        n_checks++; if (fault !== 1'b0) begin n_errors++; $display("FAIL ovf_clear got %b exp 0", fault); end
    endtask

    task automatic test_underflow();
        step(0, 0, 16'h0, 0, 1);
        step(0, 1, 16'h0, 0, 0);
        n_checks++; if (pop_valid !== 1'b0 || fault !== 1'b1) begin n_errors++; $display("FAIL udf_pop got v=%b f=%b exp 0/1", pop_valid, fault); end
        step(1, 0, 16'h7777, 0, 0);
        n_checks++; if (obs_we !== 1'b0 || depth !== 3'd0 || fault !== 1'b1) begin n_errors++; $display("FAIL udf_push_ign got we=%b d=%0d f=%b exp 0/0/1", obs_we, depth, fault); end
        step(1, 0, 16'h7778, 1, 0);
        n_checks++; if (obs_we !== 1'b0 || depth !== 3'd0 || fault !== 1'b0) begin n_errors++; $display("FAIL udf_clr_req got we=%b d=%0d f=%b exp 0/0/0", obs_we, depth, fault); end
        step(1, 0, 16'h7779, 0, 0);
        n_checks++; if (depth !== 3'd1 || ram[0] !== 16'h7779) begin n_errors++; $display("FAIL udf_resume got d=%0d ram0=%h exp 1/7779", depth, ram[0]); end
    endtask

    task automatic test_push_pop();
        step(0, 0, 16'h0, 0, 1);
        step(1, 0, 16'h1234, 0, 0);
        step(1, 0, 16'hAAAA, 0, 0);
        step(1, 1, 16'hBBBB, 0, 0);
        n_checks++; if (obs_we !== 1'b1 || obs_a !== 2'd1) begin n_errors++; $display("FAIL swap_we got we=%b a=%0d exp 1/1", obs_we, obs_a); end
        n_checks++; if (pop_valid !== 1'b1 || pop_data !== 16'hAAAA) begin n_errors++; $display("FAIL swap_pd got v=%b d=%h exp 1/aaaa", pop_valid, pop_data); end
        n_checks++; if (ram[1] !== 16'hBBBB || depth !== 3'd2) begin n_errors++; $display("FAIL swap_ram got ram1=%h d=%0d exp bbbb/2", ram[1], depth); end
        step(0, 1, 16'h0, 0, 0);
        step(0, 1, 16'h0, 0, 0);
        step(1, 1, 16'hCCCC, 0, 0);
        n_checks++; if (obs_we !== 1'b0) begin n_errors++; $display("FAIL byp_we got %b exp 0", obs_we); end
        n_checks++; if (pop_valid !== 1'b1 || pop_data !== 16'hCCCC || depth !== 3'd0) begin n_errors++; $display("FAIL byp_pd got v=%b d=%h dep=%0d exp 1/cccc/0", pop_valid, pop_data, depth); end
    endtask

    task automatic test_reset_mid();
        step(0, 0, 16'h0, 0, 1);
        for (int i = 0; i < 3; i++) step(1, 0, W'($urandom), 0, 0);
`ifdef STACK_WATERMARK_EN
        n_checks++; if (max_depth !== 3'd3) begin n_errors++; $display("FAIL wm_before got %0d exp 3", max_depth); end
`endif
        step(0, 1, 16'h0, 0, 1);
        n_checks++; if (pop_valid !== 1'b0 || depth !== 3'd0 || fault !== 1'b0) begin n_errors++; $display("FAIL rstmid got v=%b d=%0d f=%b exp 0/0/0", pop_valid, depth, fault); end
`ifdef STACK_WATERMARK_EN
        n_checks++; if (max_depth !== 3'd0) begin n_errors++; $display("FAIL wm_after got %0d exp 0", max_depth); end
`endif
    endtask

    task automatic test_random();
        bit p, o, c, r;
        step(0, 0, 16'h0, 0, 1);
        for (int n = 0; n < 400; n++) begin
            p = ($urandom_range(0, 99) < 50);
            o = ($urandom_range(0, 99) < 45);
            c = m_fault ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 15) == 0);
            r = ($urandom_range(0, 63) == 0);
            step(p, o, W'($urandom), c, r);
            n_checks++; if (obs_we !== exp_we || obs_a !== exp_a) begin n_errors++; $display("FAIL rnd_mem[%0d] got we=%b a=%0d exp %b/%0d", n, obs_we, obs_a, exp_we, exp_a); end
            n_checks++; if (pop_valid !== m_pv || pop_data !== m_pd) begin n_errors++; $display("FAIL rnd_pop[%0d] got v=%b d=%h exp %b/%h", n, pop_valid, pop_data, m_pv, m_pd); end
            n_checks++; if (depth !== 3'(q.size()) || full !== (q.size() == N) || empty !== (q.size() == 0)) begin n_errors++; $display("FAIL rnd_depth[%0d] got d=%0d f=%b e=%b exp %0d", n, depth, full, empty, q.size()); end
            n_checks++; if (fault !== m_fault) begin n_errors++; $display("FAIL rnd_fault[%0d] got %b exp %b", n, fault, m_fault); end
            for (int i = 0; i < q.size(); i++) begin
                n_checks++; if (ram[i] !== q[i]) begin n_errors++; $display("FAIL rnd_ram[%0d][%0d] got %h exp %h", n, i, ram[i], q[i]); end
            end
`ifdef STACK_WATERMARK_EN
            n_checks++; if (max_depth !== 3'(m_max)) begin n_errors++; $display("FAIL rnd_wm[%0d] got %0d exp %0d", n, max_depth, m_max); end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_lifo();
        test_overflow();
        test_underflow();
        test_push_pop();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
